// File: rtl/dfx_slave_ctrl.sv
// Slave-side slot controller for MagicSeqCore: optional DFX reprogram, descriptor latch,
// MM2S/S2MM command issue, completion wait and a per-run cycle profile.
module dfx_slave_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int SIZE_W  = 26,
    parameter int STAT_W  = 2,
    parameter int PROF_W  = 32,
    parameter int TIMEOUT = 2**20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              slaveReprog,
    output logic              slaveReprogAccept,
    input  logic              slaveInit,
    output logic              slaveFinInit,
    input  logic              slaveStartExec,
    output logic              slaveStartExecAccept,
    output logic              slaveFinExec,
    input  logic [ADDR_W-1:0] slv_src_addr,
    input  logic [SIZE_W-1:0] slv_src_size,
    input  logic [ADDR_W-1:0] slv_des_addr,
    input  logic [SIZE_W-1:0] slv_des_size,
    input  logic [STAT_W-1:0] slv_status,
    output logic              dfx_req,
    input  logic              dfx_done,
    output logic              mm2s_valid,
    input  logic              mm2s_ready,
    output logic [ADDR_W-1:0] mm2s_addr,
    output logic [SIZE_W-1:0] mm2s_len,
    input  logic              mm2s_done,
    output logic              s2mm_valid,
    input  logic              s2mm_ready,
    output logic [ADDR_W-1:0] s2mm_addr,
    output logic [SIZE_W-1:0] s2mm_len,
    input  logic              s2mm_done,
    output logic [PROF_W-1:0] prof_cycles,
    output logic              prof_valid,
    output logic              err_timeout
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, RPG, INIT, ISSUE, WAIT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_addr_q, des_addr_q;
    logic [SIZE_W-1:0] src_size_q, des_size_q;
    logic              mm2s_iss, s2mm_iss, mm2s_flag, s2mm_flag;
    logic [PROF_W-1:0] prof_cnt;
    logic [TO_W-1:0]   tmo_cnt;

    logic mm2s_iss_nxt, s2mm_iss_nxt, mm2s_flag_nxt, s2mm_flag_nxt;
    logic tmo_hit, ack_busy, status_unused;

    assign mm2s_addr = src_addr_q;
    assign mm2s_len  = src_size_q;
    assign s2mm_addr = des_addr_q;
    assign s2mm_len  = des_size_q;

    assign mm2s_iss_nxt  = mm2s_iss | (mm2s_valid & mm2s_ready);
    assign s2mm_iss_nxt  = s2mm_iss | (s2mm_valid & s2mm_ready);
    assign mm2s_flag_nxt = mm2s_flag | mm2s_done;
    assign s2mm_flag_nxt = s2mm_flag | s2mm_done;
    assign tmo_hit       = (TIMEOUT != 0) && (tmo_cnt == TO_W'(TIMEOUT - 1));
    // The core still holds its request while our completion pulse is visible; don't re-serve it.
    assign ack_busy      = slaveReprogAccept | slaveFinInit | slaveFinExec;
    assign status_unused = ^slv_status[STAT_W-1:1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                <= IDLE;
            slaveReprogAccept    <= 1'b0;
            slaveFinInit         <= 1'b0;
            slaveStartExecAccept <= 1'b0;
            slaveFinExec         <= 1'b0;
            dfx_req              <= 1'b0;
            mm2s_valid           <= 1'b0;
            s2mm_valid           <= 1'b0;
            prof_cycles          <= '0;
            prof_valid           <= 1'b0;
            err_timeout          <= 1'b0;
            src_addr_q           <= '0;
            des_addr_q           <= '0;
            src_size_q           <= '0;
            des_size_q           <= '0;
            mm2s_iss             <= 1'b0;
            s2mm_iss             <= 1'b0;
            mm2s_flag            <= 1'b0;
            s2mm_flag            <= 1'b0;
            prof_cnt             <= '0;
            tmo_cnt              <= '0;
        end else begin
            slaveReprogAccept    <= 1'b0;
            slaveFinInit         <= 1'b0;
            slaveStartExecAccept <= 1'b0;
            slaveFinExec         <= 1'b0;
            prof_valid           <= 1'b0;
            case (state)
                IDLE: begin
                    if (!ack_busy) begin
                        if (slaveReprog) begin
                            if (slv_status[0]) begin
                                dfx_req <= 1'b1;
                                tmo_cnt <= '0;
                                state   <= RPG;
                            end else begin
                                slaveReprogAccept <= 1'b1;
                            end
                        end else if (slaveInit) begin
                            src_addr_q <= slv_src_addr;
                            src_size_q <= slv_src_size;
                            des_addr_q <= slv_des_addr;
                            des_size_q <= slv_des_size;
                            state      <= INIT;
                        end else if (slaveStartExec) begin
                            // Zero-length channels count as already issued and already done.
                            mm2s_valid <= (src_size_q != '0);
                            mm2s_iss   <= (src_size_q == '0);
                            mm2s_flag  <= (src_size_q == '0);
                            s2mm_valid <= (des_size_q != '0);
                            s2mm_iss   <= (des_size_q == '0);
                            s2mm_flag  <= (des_size_q == '0);
                            state      <= ISSUE;
                        end
                    end
                end
                RPG: begin
                    if (dfx_done || tmo_hit) begin
                        if (!dfx_done) err_timeout <= 1'b1;
                        dfx_req           <= 1'b0;
                        slaveReprogAccept <= 1'b1;
                        state             <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                INIT: begin
                    slaveFinInit <= 1'b1;
                    err_timeout  <= 1'b0;
                    state        <= IDLE;
                end
                ISSUE: begin
                    mm2s_flag <= mm2s_flag_nxt;
                    s2mm_flag <= s2mm_flag_nxt;
                    mm2s_iss  <= mm2s_iss_nxt;
                    s2mm_iss  <= s2mm_iss_nxt;
                    if (mm2s_valid && mm2s_ready) mm2s_valid <= 1'b0;
                    if (s2mm_valid && s2mm_ready) s2mm_valid <= 1'b0;
                    if (mm2s_iss_nxt && s2mm_iss_nxt) begin
                        slaveStartExecAccept <= 1'b1;
                        prof_cnt             <= '0;
                        tmo_cnt              <= '0;
                        state                <= WAIT;
                    end
                end
                WAIT: begin
                    if ((mm2s_flag_nxt && s2mm_flag_nxt) || tmo_hit) begin
                        if (!(mm2s_flag_nxt && s2mm_flag_nxt)) err_timeout <= 1'b1;
                        slaveFinExec <= 1'b1;
                        prof_valid   <= 1'b1;
                        prof_cycles  <= prof_cnt;
                        mm2s_flag    <= 1'b0;
                        s2mm_flag    <= 1'b0;
                        mm2s_iss     <= 1'b0;
                        s2mm_iss     <= 1'b0;
                        mm2s_valid   <= 1'b0;
                        s2mm_valid   <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        mm2s_flag <= mm2s_flag_nxt;
                        s2mm_flag <= s2mm_flag_nxt;
                        tmo_cnt   <= tmo_cnt + 1'b1;
                        if (~&prof_cnt) prof_cnt <= prof_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dfx_slave_ctrl.sv
// Scoreboard bench for dfx_slave_ctrl: directed slots, expected events queued at issue time
// and matched by a negedge monitor against every DUT handshake/pulse.
module tb_dfx_slave_ctrl;

    localparam int ADDR_W  = 32;
    localparam int SIZE_W  = 26;
    localparam int STAT_W  = 2;
    localparam int PROF_W  = 32;
    localparam int TIMEOUT = 16;
    localparam int LIMIT   = 100;

    logic              clk, reset;
    logic              slaveReprog, slaveReprogAccept, slaveInit, slaveFinInit;
    logic              slaveStartExec, slaveStartExecAccept, slaveFinExec;
    logic [ADDR_W-1:0] slv_src_addr, slv_des_addr, mm2s_addr, s2mm_addr;
    logic [SIZE_W-1:0] slv_src_size, slv_des_size, mm2s_len, s2mm_len;
    logic [STAT_W-1:0] slv_status;
    logic              dfx_req, dfx_done;
    logic              mm2s_valid, mm2s_ready, mm2s_done;
    logic              s2mm_valid, s2mm_ready, s2mm_done;
    logic [PROF_W-1:0] prof_cycles;
    logic              prof_valid, err_timeout;

    dfx_slave_ctrl #(
        .ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .STAT_W(STAT_W), .PROF_W(PROF_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .slaveReprog(slaveReprog), .slaveReprogAccept(slaveReprogAccept),
        .slaveInit(slaveInit), .slaveFinInit(slaveFinInit),
        .slaveStartExec(slaveStartExec), .slaveStartExecAccept(slaveStartExecAccept),
        .slaveFinExec(slaveFinExec),
        .slv_src_addr(slv_src_addr), .slv_src_size(slv_src_size),
        .slv_des_addr(slv_des_addr), .slv_des_size(slv_des_size),
        .slv_status(slv_status),
        .dfx_req(dfx_req), .dfx_done(dfx_done),
        .mm2s_valid(mm2s_valid), .mm2s_ready(mm2s_ready),
        .mm2s_addr(mm2s_addr), .mm2s_len(mm2s_len), .mm2s_done(mm2s_done),
        .s2mm_valid(s2mm_valid), .s2mm_ready(s2mm_ready),
        .s2mm_addr(s2mm_addr), .s2mm_len(s2mm_len), .s2mm_done(s2mm_done),
        .prof_cycles(prof_cycles), .prof_valid(prof_valid), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event kinds: 0 reprog accept, 1 fin init, 2 start accept, 3 fin exec, 4 mm2s cmd, 5 s2mm cmd
    typedef struct {
        int          kind;
        logic [63:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mm2s_hi = 0;
    int   dfx_hi = 0;
    int   n;

    task automatic expect_ev(input int kind, input logic [63:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic score(input int kind, input logic [63:0] val, input string name);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event val=%0h, none required", name, val);
        end else begin
            e = sb_q.pop_front();
            if (e.kind != kind || e.val !== val) begin
                errors++;
                $display("FAIL %s: got kind=%0d val=%0h, required kind=%0d val=%0h",
                         name, kind, val, e.kind, e.val);
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return slaveReprogAccept;
            1:       return slaveFinInit;
            2:       return slaveStartExecAccept;
            3:       return slaveFinExec;
            4:       return mm2s_valid;
            5:       return s2mm_valid;
            6:       return dfx_req;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int w, input string name, output int cyc);
        cyc = 0;
        while (!sig(w) && cyc < LIMIT) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (!sig(w)) begin
            errors++;
            $display("FAIL %s: got 0 after %0d cycles, required 1", name, LIMIT);
        end
    endtask

    task automatic do_init(input logic [31:0] sa, input logic [25:0] ss,
                           input logic [31:0] da, input logic [25:0] ds);
        int c;
        slv_src_addr = sa;
        slv_src_size = ss;
        slv_des_addr = da;
        slv_des_size = ds;
        slaveInit    = 1'b1;
        expect_ev(1, 64'd0);
        wait_sig(1, "fin_init", c);
        slaveInit    = 1'b0;
        slv_src_addr = 32'hdead_beef;
        slv_src_size = 26'h3ff_ffff;
        slv_des_addr = 32'hfeed_f00d;
        slv_des_size = 26'h155_5555;
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (mm2s_valid) mm2s_hi++;
            if (dfx_req) dfx_hi++;
            if (mm2s_valid && mm2s_ready) score(4, {mm2s_addr, 6'b0, mm2s_len}, "mm2s_cmd");
            if (s2mm_valid && s2mm_ready) score(5, {s2mm_addr, 6'b0, s2mm_len}, "s2mm_cmd");
            if (slaveReprogAccept) score(0, {62'b0, dfx_req, err_timeout}, "reprog_accept");
            if (slaveFinInit) score(1, {63'b0, err_timeout}, "fin_init");
            if (slaveStartExecAccept) score(2, 64'd0, "start_accept");
            if (slaveFinExec) score(3, {30'b0, prof_valid, err_timeout, prof_cycles}, "fin_exec");
        end
    end

    initial begin
        int d0;
        reset = 1'b0;
        slaveReprog = 1'b0; slaveInit = 1'b0; slaveStartExec = 1'b0;
        slv_src_addr = '0; slv_src_size = '0; slv_des_addr = '0; slv_des_size = '0;
        slv_status = '0; dfx_done = 1'b0;
        mm2s_ready = 1'b0; mm2s_done = 1'b0; s2mm_ready = 1'b0; s2mm_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pulses", {slaveReprogAccept, slaveFinInit, slaveStartExecAccept, slaveFinExec}, 0);
        check("reset_cmds", {dfx_req, mm2s_valid, s2mm_valid, prof_valid, err_timeout}, 0);
        check("reset_prof", prof_cycles, 0);
        check("reset_desc", {mm2s_addr, 6'b0, mm2s_len}, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reprogram needed: DFX completes 5 cycles after request
        slv_status = 2'b01;
        expect_ev(0, 64'd0);
        slaveReprog = 1'b1;
        wait_sig(6, "dfx_req_rise", n);
        repeat (4) @(posedge clk);
        #1 dfx_done = 1'b1;
        @(posedge clk);
        #1 dfx_done = 1'b0;
        wait_sig(0, "reprog_accept_rpg", n);
        slaveReprog = 1'b0;
        slv_status = '0;
        check("dfx_req_low_after_done", dfx_req, 0);
        repeat (3) @(posedge clk);
        #1;
        check("dfx_req_still_low", dfx_req, 0);

        // Reprogram skipped: accept one cycle later, dfx_req never raised
        d0 = dfx_hi;
        slv_status = 2'b10;
        expect_ev(0, 64'd0);
        slaveReprog = 1'b1;
        @(posedge clk);
        #1;
        check("reprog_skip_latency", slaveReprogAccept, 1);
        slaveReprog = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reprog_skip_no_dfx_req", dfx_hi, d0);
        slv_status = '0;

        // Stray completions in IDLE must be dropped
        mm2s_done = 1'b1; s2mm_done = 1'b1; dfx_done = 1'b1;
        @(posedge clk);
        #1 mm2s_done = 1'b0; s2mm_done = 1'b0; dfx_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Main run: ready after 3 cycles, done at +10/+12 from accept
        do_init(32'h1000, 26'd64, 32'h2000, 26'd64);
        expect_ev(4, {32'h1000, 32'd64});
        expect_ev(5, {32'h2000, 32'd64});
        expect_ev(2, 64'd0);
        expect_ev(3, {30'b0, 1'b1, 1'b0, 32'd12});
        slaveStartExec = 1'b1;
        wait_sig(4, "mm2s_valid_rise", n);
        repeat (3) @(posedge clk);
        #1 mm2s_ready = 1'b1; s2mm_ready = 1'b1;
        @(posedge clk);
        #1 mm2s_ready = 1'b0; s2mm_ready = 1'b0;
        wait_sig(2, "start_accept_main", n);
        slaveStartExec = 1'b0;
        repeat (10) @(posedge clk);
        #1 mm2s_done = 1'b1;
        @(posedge clk);
        #1 mm2s_done = 1'b0;
        @(posedge clk);
        #1 s2mm_done = 1'b1;
        @(posedge clk);
        #1 s2mm_done = 1'b0;
        wait_sig(3, "fin_exec_main", n);
        repeat (2) @(posedge clk);
        #1;

        // MM2S length 0: only S2MM issued
        d0 = mm2s_hi;
        do_init(32'h3333, 26'd0, 32'h3000, 26'd128);
        expect_ev(5, {32'h3000, 32'd128});
        expect_ev(2, 64'd0);
        expect_ev(3, {30'b0, 1'b1, 1'b0, 32'd5});
        s2mm_ready = 1'b1;
        slaveStartExec = 1'b1;
        wait_sig(2, "start_accept_mm2s_skip", n);
        s2mm_ready = 1'b0;
        slaveStartExec = 1'b0;
        repeat (5) @(posedge clk);
        #1 s2mm_done = 1'b1;
        @(posedge clk);
        #1 s2mm_done = 1'b0;
        wait_sig(3, "fin_exec_mm2s_skip", n);
        check("mm2s_valid_never_high", mm2s_hi, d0);
        repeat (2) @(posedge clk);
        #1;

        // S2MM done arrives before the MM2S command handshake
        do_init(32'h4000, 26'd32, 32'h5000, 26'd16);
        expect_ev(5, {32'h5000, 32'd16});
        expect_ev(4, {32'h4000, 32'd32});
        expect_ev(2, 64'd0);
        expect_ev(3, {30'b0, 1'b1, 1'b0, 32'd3});
        slaveStartExec = 1'b1;
        wait_sig(5, "s2mm_valid_rise", n);
        s2mm_ready = 1'b1;
        @(posedge clk);
        #1 s2mm_ready = 1'b0; s2mm_done = 1'b1;
        @(posedge clk);
        #1 s2mm_done = 1'b0;
        @(posedge clk);
        #1;
        check("early_done_no_fin", {slaveFinExec, slaveStartExecAccept}, 0);
        mm2s_ready = 1'b1;
        @(posedge clk);
        #1 mm2s_ready = 1'b0;
        wait_sig(2, "start_accept_early", n);
        slaveStartExec = 1'b0;
        repeat (3) @(posedge clk);
        #1 mm2s_done = 1'b1;
        @(posedge clk);
        #1 mm2s_done = 1'b0;
        wait_sig(3, "fin_exec_early", n);
        repeat (2) @(posedge clk);
        #1;

        // Both lengths 0: accept then FinExec the next cycle
        d0 = mm2s_hi;
        do_init(32'h8000, 26'd0, 32'h9000, 26'd0);
        expect_ev(2, 64'd0);
        expect_ev(3, {30'b0, 1'b1, 1'b0, 32'd0});
        slaveStartExec = 1'b1;
        wait_sig(2, "start_accept_zero", n);
        slaveStartExec = 1'b0;
        @(posedge clk);
        #1;
        check("fin_exec_after_zero_len", slaveFinExec, 1);
        check("zero_len_no_mm2s", mm2s_hi, d0);
        repeat (2) @(posedge clk);
        #1;

        // Timeout in WAIT, then cleared by the next init
        do_init(32'h6000, 26'd8, 32'h7000, 26'd8);
        expect_ev(4, {32'h6000, 32'd8});
        expect_ev(5, {32'h7000, 32'd8});
        expect_ev(2, 64'd0);
        expect_ev(3, {30'b0, 1'b1, 1'b1, 32'd15});
        mm2s_ready = 1'b1; s2mm_ready = 1'b1;
        slaveStartExec = 1'b1;
        wait_sig(2, "start_accept_tmo", n);
        mm2s_ready = 1'b0; s2mm_ready = 1'b0;
        slaveStartExec = 1'b0;
        wait_sig(3, "fin_exec_tmo", n);
        check("timeout_latency", n, TIMEOUT);
        repeat (2) @(posedge clk);
        #1;
        check("err_timeout_sticky", err_timeout, 1);
        do_init(32'h0, 26'd0, 32'h0, 26'd0);
        check("err_timeout_cleared", err_timeout, 0);

        // Reset during a reprogram: no completion pulse
        slv_status = 2'b01;
        slaveReprog = 1'b1;
        wait_sig(6, "dfx_req_before_reset", n);
        #2 reset = 1'b0;
        #1;
        check("reset_async_dfx_req", dfx_req, 0);
        slaveReprog = 1'b0;
        slv_status = '0;
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("after_reset_quiet", {dfx_req, slaveReprogAccept, err_timeout}, 0);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
